// File: rtl/sdp_core_triosy_mch_wait_ctrl_dp.sv
// Multi-channel triosy wait controller: per-channel issue/done strobes, held completions,
// lz generation, plus a shared saturating completion counter and sticky all-done flag.
module sdp_core_triosy_mch_wait_ctrl_dp #(
   parameter int NCH       = 4,
   parameter int CNT_W     = 8,
   parameter bit PULSE_DEF = 1'b0
) (
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rst,
   input  logic             core_wen,
   input  logic             core_wten,
   input  logic [NCH-1:0]   oswt,
   input  logic [NCH-1:0]   iswt0,
   input  logic             cfg_pulse_mode,
   input  logic             cfg_load,
   input  logic             cnt_clr,
   output logic [NCH-1:0]   biwt,
   output logic [NCH-1:0]   bdwt,
   output logic [NCH-1:0]   bcwt,
   output logic [NCH-1:0]   triosy_lz,
   output logic [CNT_W-1:0] done_cnt,
   output logic             all_done
);

   localparam int SUM_W = CNT_W + 5;
   localparam logic [SUM_W-1:0] CNT_MAX = {5'b0, {CNT_W{1'b1}}};

   logic [NCH-1:0]   bcwt_q, bcwt_d;
   logic [NCH-1:0]   seen_q, seen_d;
   logic [NCH-1:0]   ev;
   logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
   logic             all_done_q, all_done_d;
   logic             mode_q, mode_d;
   logic [SUM_W-1:0] ev_cnt;
   logic [SUM_W-1:0] cnt_sum;

   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign biwt[gi]      = iswt0[gi] & ~core_wten;
      assign bdwt[gi]      = oswt[gi] & core_wen;
      // A consume in the same cycle as an issue wins: nothing is held.
      assign bcwt_d[gi]    = (bcwt_q[gi] | biwt[gi]) & ~bdwt[gi];
      assign ev[gi]        = biwt[gi] & ~bcwt_q[gi];
      assign triosy_lz[gi] = mode_q ? ev[gi] : (biwt[gi] | bcwt_q[gi]);
   end

   always_comb begin
      ev_cnt = '0;
      for (int k = 0; k < NCH; k++) begin
         ev_cnt = ev_cnt + SUM_W'(ev[k]);
      end
      cnt_sum = SUM_W'(done_cnt_q) + ev_cnt;

      done_cnt_d = done_cnt_q;
      seen_d     = seen_q | ev;
      all_done_d = all_done_q | (&(seen_q | ev));
      if (cnt_clr) begin
         done_cnt_d = '0;
         seen_d     = '0;
         all_done_d = 1'b0;
      end else if (cnt_sum > CNT_MAX) begin
         done_cnt_d = '1;
      end else begin
         done_cnt_d = cnt_sum[CNT_W-1:0];
      end

      mode_d = cfg_load ? cfg_pulse_mode : mode_q;
   end

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         bcwt_q     <= '0;
         seen_q     <= '0;
         done_cnt_q <= '0;
         all_done_q <= 1'b0;
         mode_q     <= PULSE_DEF;
      end else begin
         bcwt_q     <= bcwt_d;
         seen_q     <= seen_d;
         done_cnt_q <= done_cnt_d;
         all_done_q <= all_done_d;
         mode_q     <= mode_d;
      end
   end

   assign bcwt     = bcwt_q;
   assign done_cnt = done_cnt_q;
   assign all_done = all_done_q;

endmodule

// File: tb/tb_sdp_core_triosy_mch_wait_ctrl_dp.sv
// Scoreboard bench: directed scenarios then random traffic, checked against a
// per-channel pending/count model derived from the handshake rules.
module tb_sdp_core_triosy_mch_wait_ctrl_dp;
   localparam int NCH   = 4;
   localparam int CNT_W = 3;
   localparam int CMAX  = 7;
   localparam bit PDEF  = 1'b0;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             core_wen = 1'b0, core_wten = 1'b0;
   logic [NCH-1:0]   oswt = '0, iswt0 = '0;
   logic             cfg_pulse_mode = 1'b0, cfg_load = 1'b0, cnt_clr = 1'b0;
   logic [NCH-1:0]   biwt, bdwt, bcwt, triosy_lz;
   logic [CNT_W-1:0] done_cnt;
   logic             all_done;

   sdp_core_triosy_mch_wait_ctrl_dp #(.NCH(NCH), .CNT_W(CNT_W), .PULSE_DEF(PDEF)) dut (
      .nvdla_core_clk(clk), .nvdla_core_rst(rst),
      .core_wen(core_wen), .core_wten(core_wten),
      .oswt(oswt), .iswt0(iswt0),
      .cfg_pulse_mode(cfg_pulse_mode), .cfg_load(cfg_load), .cnt_clr(cnt_clr),
      .biwt(biwt), .bdwt(bdwt), .bcwt(bcwt), .triosy_lz(triosy_lz),
      .done_cnt(done_cnt), .all_done(all_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NCH-1:0]   biwt, bdwt, bcwt, lz;
      logic [CNT_W-1:0] cnt;
      logic             alld;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   ncyc = 0;

   // Reference state: what each channel is holding, how many completions, etc.
   bit pend[NCH];
   bit seen[NCH];
   int cnt  = 0;
   bit alld = 0;
   bit mode = PDEF;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, ncyc, act, req);
      end
   endtask

   // Monitor: every cycle the DUT presents a full output set; compare against the head of the queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("biwt", int'(biwt), int'(e.biwt));
            chk("bdwt", int'(bdwt), int'(e.bdwt));
            chk("bcwt", int'(bcwt), int'(e.bcwt));
            chk("triosy_lz", int'(triosy_lz), int'(e.lz));
            chk("done_cnt", int'(done_cnt), int'(e.cnt));
            chk("all_done", int'(all_done), int'(e.alld));
            $display("cyc %0d biwt=%h bdwt=%h bcwt=%h lz=%h cnt=%0d all_done=%0d",
                     ncyc, biwt, bdwt, bcwt, triosy_lz, done_cnt, all_done);
            ncyc++;
         end
      end
   end

   task automatic cyc(input bit r, input bit wen, input bit wten,
                      input logic [NCH-1:0] os, input logic [NCH-1:0] is,
                      input bit pm, input bit ld, input bit clr);
      exp_t e;
      bit   iss[NCH];
      bit   dn[NCH];
      bit   evv[NCH];
      int   nev;
      bit   allv;
      @(negedge clk);
      rst = r; core_wen = wen; core_wten = wten; oswt = os; iswt0 = is;
      cfg_pulse_mode = pm; cfg_load = ld; cnt_clr = clr;
      if (r) begin
         for (int i = 0; i < NCH; i++) begin
            pend[i] = 0;
            seen[i] = 0;
         end
         cnt = 0; alld = 0; mode = PDEF;
      end
      nev = 0; allv = 1;
      for (int i = 0; i < NCH; i++) begin
         iss[i] = is[i] && !wten;
         dn[i]  = os[i] && wen;
         evv[i] = iss[i] && !pend[i];
         if (evv[i]) nev++;
         if (!(seen[i] || evv[i])) allv = 0;
         e.biwt[i] = iss[i];
         e.bdwt[i] = dn[i];
         e.bcwt[i] = pend[i];
         e.lz[i]   = mode ? evv[i] : (iss[i] || pend[i]);
      end
      e.cnt  = CNT_W'(cnt);
      e.alld = alld;
      q.push_back(e);
      if (!r) begin
         for (int i = 0; i < NCH; i++) begin
            pend[i] = dn[i] ? 1'b0 : (pend[i] || iss[i]);
            seen[i] = clr ? 1'b0 : (seen[i] || evv[i]);
         end
         cnt  = clr ? 0 : ((cnt + nev > CMAX) ? CMAX : cnt + nev);
         alld = clr ? 1'b0 : (alld || allv);
         if (ld) mode = pm;
      end
   endtask

   initial begin
      // args: rst, wen, wten, oswt, iswt0, pm, load, clr
      cyc(1, 0, 0, 4'h0, 4'h0, 0, 0, 0);
      cyc(0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
      // Stall hold on ch0, then consume
      cyc(0, 0, 0, 4'h0, 4'h1, 0, 0, 0);
      repeat (5) cyc(0, 0, 1, 4'h1, 4'h1, 0, 0, 0);
      cyc(0, 1, 0, 4'h1, 4'h0, 0, 0, 0);
      cyc(0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
      // Same-cycle issue and consume on ch2
      cyc(0, 1, 0, 4'h4, 4'h4, 0, 0, 0);
      cyc(0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
      // all_done: ch0..ch3 in separate cycles (clear first), then clear with a new event
      cyc(0, 1, 0, 4'hF, 4'h0, 0, 0, 1);
      for (int i = 0; i < NCH; i++) cyc(0, 1, 0, 4'hF, 4'(1 << i), 0, 0, 0);
      cyc(0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
      cyc(0, 1, 0, 4'hF, 4'h1, 0, 0, 1);
      cyc(0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
      // Saturation: reach 5, then two cycles of 4 fresh events, then clear with events pending
      cyc(0, 1, 0, 4'hF, 4'hF, 0, 0, 0);
      cyc(0, 1, 0, 4'hF, 4'h1, 0, 0, 0);
      cyc(0, 1, 0, 4'hF, 4'hF, 0, 0, 0);
      cyc(0, 1, 0, 4'hF, 4'hF, 0, 0, 0);
      cyc(0, 1, 0, 4'hF, 4'h3, 0, 0, 1);
      cyc(0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
      // Pulse mode: ch1 held for three cycles without consume
      cyc(0, 0, 0, 4'h0, 4'h0, 1, 1, 0);
      repeat (3) cyc(0, 0, 0, 4'h0, 4'h2, 0, 0, 0);
      cyc(0, 1, 0, 4'hF, 4'h0, 0, 1, 0);
      // Reset mid-hold with bcwt=0101
      cyc(0, 0, 0, 4'h0, 4'h5, 0, 0, 0);
      cyc(1, 0, 0, 4'h0, 4'h0, 0, 0, 0);
      cyc(0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
      // Random traffic
      for (int n = 0; n < 600; n++) begin
         cyc(($urandom_range(0, 99) == 0),
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) == 0,
             4'($urandom), 4'($urandom),
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 19) == 0,
             $urandom_range(0, 11) == 0);
      end
      repeat (3) @(negedge clk);
      #3;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain remaining=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sdp_core_triosy_mch_wait_ctrl_dp.md
Name: sdp_core_triosy_mch_wait_ctrl_dp

Overview:
- Parametrised multi-channel triosy wait controller plus datapath for SDP core handshakes.
- Each channel generates the combinational issue (biwt) and done (bdwt) strobes from the shared core enables.
- Each channel holds a completion registered while the core is stalled (bcwt) and drives a per-channel triosy lz output.
- Shared logic adds a saturating completion counter and a sticky all-channels-complete flag for the SDP core sequencer.

Parameters:
- NCH, 4, number of independent triosy channels (1..16)
- CNT_W, 8, width of the completion counter
- PULSE_DEF, 0, reset value of the internal mode register (0 = level lz, 1 = pulse lz)

Ports:
- nvdla_core_clk  in  1  core clock; all state updates on its rising edge
- nvdla_core_rst  in  1  asynchronous, active-high reset
- core_wen  in  1  core write enable, shared by all channels
- core_wten  in  1  core wait/stall, shared by all channels; 1 = stalled
- oswt  in  NCH  per-channel output-side wait request
- iswt0  in  NCH  per-channel issue request
- cfg_pulse_mode  in  1  lz mode; sampled into the mode register when cfg_load=1
- cfg_load  in  1  loads cfg_pulse_mode into the mode register
- cnt_clr  in  1  synchronous clear of done_cnt and all_done
- biwt  out  NCH  per-channel issue strobe (combinational)
- bdwt  out  NCH  per-channel done strobe (combinational)
- bcwt  out  NCH  per-channel held-completion register
- triosy_lz  out  NCH  per-channel triosy output
- done_cnt  out  CNT_W  saturating count of new completions
- all_done  out  1  sticky flag: every channel has completed since the last clear

Behaviour:
- Reset values: bcwt=0, done_cnt=0, all_done=0, mode=PULSE_DEF.
- Reset is asynchronous; assertion mid-operation discards held completions immediately.
- Combinational outputs, per channel i:
  - biwt[i] = iswt0[i] & ~core_wten
  - bdwt[i] = oswt[i] & core_wen
- Hold register: bcwt[i] next = (bcwt[i] | biwt[i]) & ~bdwt[i].
  - bdwt wins over a simultaneous biwt: the completion is consumed in the same cycle and is not held.
- New-completion event: ev[i] = biwt[i] & ~bcwt[i].
  - A biwt arriving while bcwt[i]=1 does not create a second event.
- triosy_lz[i]:
  - level mode (mode=0): biwt[i] | bcwt[i]
  - pulse mode (mode=1): ev[i]
  - Zero cycles of latency from biwt in both modes.
- Mode register loads only when cfg_load=1. The new mode takes effect from the next cycle. Held bcwt bits are unaffected by a mode change.
- done_cnt next:
  - cnt_clr=1 -> 0; events occurring in that cycle are discarded.
  - otherwise done_cnt + popcount(ev). The sum is computed at CNT_W+5 bits and clamped to 2^CNT_W-1 (saturating, no wrap).
- Completion tracker: an internal seen[NCH] register.
  - seen[i] is set by ev[i].
  - all seen bits clear on cnt_clr or reset.
- all_done:
  - set the cycle after seen|ev becomes all ones;
  - remains 1 until cnt_clr;
  - cnt_clr has priority over a simultaneous set.
- core_wten=1 blocks all new biwt; held bcwt bits persist through a stall of any length.
- core_wen=0 blocks bdwt; bcwt therefore holds until core_wen and oswt are both 1.
- NCH=1 is legal; all_done then tracks the single channel's first completion.

Test Plan:
- Reset mid-hold: with bcwt=4'b0101, assert nvdla_core_rst asynchronously -> bcwt, done_cnt and all_done read 0 before the next clock edge.
- Stall hold: NCH=4. Ch0 iswt0=1 with core_wten=0 for 1 cycle, then core_wten=1 and core_wen=0 for 5 cycles -> bcwt[0]=1 for all 5 cycles; level triosy_lz[0]=1 throughout; done_cnt=1. Then oswt[0]=1 with core_wen=1 -> bcwt[0]=0 on the next cycle.
- Same-cycle consume: iswt0[2]=1, oswt[2]=1, core_wen=1, core_wten=0 -> biwt[2]=1, bdwt[2]=1, bcwt[2] stays 0, done_cnt +1.
- Pulse mode: cfg_load=1 with cfg_pulse_mode=1; hold iswt0[1]=1 for 3 cycles with core_wen=0 -> triosy_lz[1] high for the first cycle only; done_cnt +1.
- Saturation: CNT_W=3. Drive 4 channels with fresh events for 2 cycles starting from done_cnt=5 -> done_cnt=7 and stays 7; cnt_clr asserted with 2 events pending -> done_cnt=0.
- all_done: events on ch0, ch1, ch2, then ch3 in separate cycles -> all_done=1 the cycle after ch3's event. cnt_clr together with a new event -> all_done=0, done_cnt=0.
